piso_serializer: RTL and testbench

//   Parallel-in/serial-out transmitter. Takes a WIDTH-bit word on a valid/ready

---
 rtl/serial_pkg.sv | 24 ++
 rtl/ser_bit_counter.sv | 41 ++++
 rtl/piso_serializer.sv | 156 +++++++++++++++
 tb/tb_piso_serializer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_pkg
// Description : State encodings and sizing helper shared by the serial
//               transmit (PISO) and receive (SIPO) paths.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  // Serializer / deserializer state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  // Number of bits needed to index n items (minimum 1 for n >= 2)
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : ser_bit_counter
// Description : Load/enable bit counter with terminal-count flag raised when
//               the count reaches WIDTH-1. Asynchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  localparam logic [CW-1:0] c_TERM = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  // Load (to zero) takes priority over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == c_TERM);

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word
//               on a valid/ready handshake and emits it one bit per clock with
//               per-bit valid and an end-of-word marker.
//               Build option: define PARITY_EN to append an even-parity beat
//               after the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int            CW           = clog2(WIDTH);
  localparam logic [CW-1:0] c_CNT_PENULT = CW'(WIDTH - 2);
`ifdef PARITY_EN
  localparam bit            c_LAST_ON_DATA = 1'b0;
`else
  localparam bit            c_LAST_ON_DATA = 1'b1;
`endif

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_ser_last;
  logic             r_busy;
`ifdef PARITY_EN
  logic             r_parity;
`endif

  logic [CW-1:0]    w_count;
  logic             w_tc;
  logic             w_pen;
  logic             w_final;
  logic             w_accept;
  logic             w_shifting;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_shift;
  logic [WIDTH-1:0] w_step_shift;

  // Bit ordering: the first bit leaves directly from in_data, the remainder
  // is parked in the shift register pre-shifted by one position.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_first_bit  = in_data[WIDTH-1];
      assign w_load_shift = {in_data[WIDTH-2:0], 1'b0};
      assign w_next_bit   = r_shift[WIDTH-1];
      assign w_step_shift = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit  = in_data[0];
      assign w_load_shift = {1'b0, in_data[WIDTH-1:1]};
      assign w_next_bit   = r_shift[0];
      assign w_step_shift = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

`ifdef PARITY_EN
  assign w_final = (r_state == ST_PARITY);
`else
  assign w_final = (r_state == ST_SHIFT) && w_tc;
`endif

  assign in_ready   = rst && ((r_state == ST_IDLE) || w_final);
  assign w_accept   = in_valid && in_ready;
  assign w_shifting = (r_state == ST_SHIFT) && !w_tc;
  assign w_pen      = (w_count == c_CNT_PENULT);

  // Counter tracks the index of the bit currently on ser_out; parked at zero
  // whenever no data bit is being advanced.
  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (!w_shifting),
    .i_en    (w_shifting),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

`ifdef PARITY_EN
  // Even parity of the accepted word, replayed after the data bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^in_data;
    end
  end
`endif

  // FSM and output registers: accept, advance a data bit, parity beat, or idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_SHIFT;
      r_shift     <= w_load_shift;
      r_ser_out   <= w_first_bit;
      r_ser_valid <= 1'b1;
      r_ser_last  <= 1'b0;
      r_busy      <= 1'b1;
    end else if (w_shifting) begin
      r_shift     <= w_step_shift;
      r_ser_out   <= w_next_bit;
      r_ser_valid <= 1'b1;
      r_ser_last  <= w_pen && c_LAST_ON_DATA;
      r_busy      <= 1'b1;
    end
`ifdef PARITY_EN
    else if (r_state == ST_SHIFT) begin
      r_state     <= ST_PARITY;
      r_ser_out   <= r_parity;
      r_ser_valid <= 1'b1;
      r_ser_last  <= 1'b1;
      r_busy      <= 1'b1;
    end
`endif
    else begin
      r_state     <= ST_IDLE;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
      r_busy      <= 1'b0;
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign ser_last  = r_ser_last;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Scoreboard bench for piso_serializer. Two instances share
//               clk/rst: index 0 is MSB-first, index 1 is LSB-first. Build
//               option PARITY_EN selects the parity-beat expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PARITY_EN
  localparam int PER = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int PER = W;
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    int   cyc;
    logic b;
    logic last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data   [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         ser_out   [2];
  logic         ser_valid [2];
  logic         ser_last  [2];
  logic         busy      [2];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_last(ser_last[0]), .busy(busy[0])
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_last(ser_last[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // seq holds the bits in send order, first-sent bit at seq[W-1]
  task automatic expect_word(input int d, input int k, input logic [W-1:0] seq, input logic par);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.cyc  = k + i;
      e.b    = seq[W-1-i];
      e.last = (i == W - 1) && !PAR;
      push(d, e);
    end
    if (PAR) begin
      e.cyc  = k + W;
      e.b    = par;
      e.last = 1'b1;
      push(d, e);
    end
  endtask

  // Monitor: compare one instance's serial outputs against the scoreboard
  task automatic mon(input int d);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (d == 0) begin
      while (q0.size() > 0 && q0[0].cyc < cyc) begin
        e = q0.pop_front();
        check($sformatf("dut%0d missed bit", d), 32'd0, 32'd1);
      end
      if (q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      while (q1.size() > 0 && q1[0].cyc < cyc) begin
        e = q1.pop_front();
        check($sformatf("dut%0d missed bit", d), 32'd0, 32'd1);
      end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      check($sformatf("dut%0d ser_valid", d), ser_valid[d], 1);
      check($sformatf("dut%0d ser_out", d),   ser_out[d],   e.b);
      check($sformatf("dut%0d ser_last", d),  ser_last[d],  e.last);
    end else begin
      check($sformatf("dut%0d idle ser_valid", d), ser_valid[d], 0);
      check($sformatf("dut%0d idle ser_out", d),   ser_out[d],   0);
      check($sformatf("dut%0d idle ser_last", d),  ser_last[d],  0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Call at negedge+1; returns at negedge+1 of the first-bit cycle k
  task automatic send(input int d, input logic [W-1:0] w, input logic [W-1:0] seq,
                      input logic par, output int k);
    bit ok;
    ok = 1'b0;
    k  = -1;
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    for (int t = 0; t < 3 * PER && !ok; t++) begin
      if (in_ready[d] === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL dut%0d accept timeout: in_ready 0 expected 1", d);
      in_valid[d] = 1'b0;
    end else begin
      k = cyc + 1;
      expect_word(d, k, seq, par);
      @(negedge clk);
      #1;
      in_valid[d] = 1'b0;
      check($sformatf("dut%0d busy after accept", d), busy[d], 1);
    end
  endtask

  // in_ready must be high only on the final-bit cycle of the word started at k
  task automatic watch_ready(input int d, input int k);
    while (cyc <= k + PER - 1) begin
      check($sformatf("dut%0d in_ready in word", d), in_ready[d], (cyc == k + PER - 1));
      @(negedge clk);
      #1;
    end
    check($sformatf("dut%0d in_ready idle", d), in_ready[d], 1);
    check($sformatf("dut%0d busy idle", d), busy[d], 0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic settle();
    repeat (PER + 2) @(negedge clk);
    #1;
  endtask

  initial begin
    int k, k2;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_data[d]  = '0;
      in_valid[d] = 1'b0;
    end

    // Reset state
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d rst in_ready", d),  in_ready[d],  0);
      check($sformatf("dut%0d rst ser_valid", d), ser_valid[d], 0);
      check($sformatf("dut%0d rst ser_out", d),   ser_out[d],   0);
      check($sformatf("dut%0d rst ser_last", d),  ser_last[d],  0);
      check($sformatf("dut%0d rst busy", d),      busy[d],      0);
    end
    #13 rst = 1'b1;
    @(negedge clk);
    #1;
    check("dut0 in_ready after release", in_ready[0], 1);
    check("dut1 in_ready after release", in_ready[1], 1);

    // MSB-first A5 from idle
    send(0, 8'hA5, 8'hA5, 1'b0, k);
    watch_ready(0, k);

    // LSB-first 01 then 80 back-to-back: sent 1,0000000 then 0000000,1
    send(1, 8'h01, 8'h80, 1'b1, k);
    send(1, 8'h80, 8'h01, 1'b1, k2);
    check("b2b zero-gap start", k2, k + PER);
    settle();

    // FF accepted, 00 offered mid-word: held off until the final-bit cycle
    send(0, 8'hFF, 8'hFF, 1'b0, k);
    wait_until(k + 2);
    check("in_ready while busy", in_ready[0], 0);
    send(0, 8'h00, 8'h00, 1'b0, k2);
    check("held word start", k2, k + PER);
    settle();

    // Reset pulse while bit 4 of C3 is on the line
    send(0, 8'hC3, 8'hC3, 1'b0, k);
    wait_until(k + 4);
    rst = 1'b0;
    #1;
    check("midrst ser_valid", ser_valid[0], 0);
    check("midrst ser_last",  ser_last[0],  0);
    check("midrst busy",      busy[0],      0);
    check("midrst in_ready",  in_ready[0],  0);
    q0.delete();
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready after midrst", in_ready[0], 1);
    send(0, 8'hC3, 8'hC3, 1'b0, k);
    watch_ready(0, k);

    // 07: parity 1 when the parity beat is built in
    send(0, 8'h07, 8'h07, 1'b1, k);
    watch_ready(0, k);

    settle();
    check("dut0 scoreboard drained", q0.size(), 0);
    check("dut1 scoreboard drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
